mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_pkg.sv | 16 +
 rtl/mul_sequencer_adder.sv | 15 +
 rtl/mul_sequencer.sv | 104 ++++++++++
 tb/tb_mul_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_sequencer_pkg;

  // Default operand/result width.
  localparam int unsigned MulN = 64;

  // Iteration counter width: it must be able to hold the value N.
  localparam int unsigned MulCntW = $clog2(MulN + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mul_state_e;

endpackage

// File: rtl/mul_sequencer_adder.sv
// Plain N-bit adder used for the accumulate step. The carry-out is dropped,
// so the sum wraps modulo 2^N.
module mul_sequencer_adder
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned N = MulN
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL unit for the execute stage. It stalls the front of the
// pipeline while it runs N shift-and-add iterations, then pulses done_E for
// one cycle with the low N bits of the product.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned N = MulN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_E,
  input  logic         flush_E,
  input  logic [N-1:0] opA_E,
  input  logic [N-1:0] opB_E,
  output logic         stall_E,
  output logic         busy,
  output logic         done_E,
  output logic [N-1:0] product_E
);

  localparam int unsigned CntW = $clog2(N + 1);

  mul_state_e      state_q;
  logic [N-1:0]    mcand_q;
  logic [N-1:0]    mplier_q;
  logic [N-1:0]    acc_q;
  logic [N-1:0]    product_q;
  logic [N-1:0]    prev_q;     // product before the latest load, restored on a DONE flush
  logic [CntW-1:0] cnt_q;

  logic [N-1:0]    addend;
  logic [N-1:0]    acc_sum;
  logic            launch;
  logic            last_iter;
  logic            drop_done;

  // A flush in the same cycle as start_E squashes the MUL, so no launch.
  assign launch    = (state_q == StIdle) && start_E && !flush_E;
  assign last_iter = (cnt_q == CntW'(N - 1));
  assign drop_done = (state_q == StDone) && flush_E;
  assign addend    = mplier_q[0] ? mcand_q : '0;

  mul_sequencer_adder #(
    .N (N)
  ) u_adder (
    .a   (acc_q),
    .b   (addend),
    .sum (acc_sum)
  );

  // Pipeline handshake; all forced low while reset is asserted.
  assign stall_E   = !reset && (launch || (state_q == StRun));
  assign busy      = !reset && (state_q != StIdle);
  assign done_E    = !reset && (state_q == StDone) && !flush_E;
  assign product_E = drop_done ? prev_q : product_q;

  // FSM, iteration counter and shift/accumulate datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            mcand_q  <= opA_E;
            mplier_q <= opB_E;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (flush_E) begin
            state_q <= StIdle;
          end else begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last_iter) begin
              prev_q    <= product_q;
              product_q <= acc_sum;
              state_q   <= StDone;
            end
          end
        end
        StDone: begin
          if (flush_E) begin
            product_q <= prev_q;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with a product/latency scoreboard.
module tb_mul_sequencer;

  localparam int unsigned N   = 64;
  localparam int unsigned Lat = N + 1;

  logic         clk;
  logic         reset;
  logic         start_E;
  logic         flush_E;
  logic [N-1:0] opA_E;
  logic [N-1:0] opB_E;
  logic         stall_E;
  logic         busy;
  logic         done_E;
  logic [N-1:0] product_E;

  typedef struct {
    logic [N-1:0] prod;
    int unsigned  cyc;
  } sb_t;

  sb_t         sb[$];
  int unsigned cyc;
  int unsigned done_cnt;
  int unsigned n_cmp;
  int unsigned n_err;

  mul_sequencer #(
    .N (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_E   (start_E),
    .flush_E   (flush_E),
    .opA_E     (opA_E),
    .opB_E     (opB_E),
    .stall_E   (stall_E),
    .busy      (busy),
    .done_E    (done_E),
    .product_E (product_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done_E pulse must match the oldest outstanding multiply.
  always @(negedge clk) begin
    if (!reset && done_E) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("sb_product", product_E, e.prod);
        check("sb_latency", N'(cyc), N'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start cycle; leaves the bench one cycle later with start_E low.
  task automatic start_mul(input logic [N-1:0] a, input logic [N-1:0] b, input bit expect_done);
    sb_t e;
    opA_E   = a;
    opB_E   = b;
    start_E = 1'b1;
    flush_E = 1'b0;
    #1;
    check("stall_on_start", stall_E, 1'b1);
    if (expect_done) begin
      e.prod = a * b;
      e.cyc  = cyc + Lat;
      sb.push_back(e);
    end
    tick();
    start_E = 1'b0;
    opA_E   = $urandom();
    opB_E   = $urandom();
    check("busy_in_run", busy, 1'b1);
  endtask

  // Bounded wait for the next done_E pulse.
  task automatic wait_done(input string tag);
    int unsigned d0;
    d0 = done_cnt;
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
      #1;
    end
    check(tag, N'(done_cnt != d0), N'(1));
    tick();
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    int unsigned d0;
    int unsigned bad;
    logic [N-1:0] a;
    logic [N-1:0] b;

    cyc      = 0;
    done_cnt = 0;
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start_E  = 1'b1;
    flush_E  = 1'b0;
    opA_E    = 64'd9;
    opB_E    = 64'd9;
    #12;
    check("rst_stall", stall_E, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done_E, 1'b0);
    check("rst_product", product_E, '0);
    start_E = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // 3*5: stall high from start through the last RUN cycle, done at t+65.
    start_mul(64'd3, 64'd5, 1'b1);
    bad = 0;
    for (int i = 1; i < Lat; i++) begin
      if (stall_E !== 1'b1 || done_E !== 1'b0) bad++;
      tick();
    end
    check("stall_run_cycles", N'(bad), '0);
    check("done_at_t65", done_E, 1'b1);
    check("stall_in_done", stall_E, 1'b0);
    check("product_3x5", product_E, 64'd15);
    tick();
    check("done_one_cycle", done_E, 1'b0);
    check("product_hold", product_E, 64'd15);

    // All-ones squared wraps to 1.
    start_mul('1, '1, 1'b1);
    wait_done("done_wrap");
    check("product_wrap", product_E, 64'h1);

    // Zero multiplier still takes the full latency.
    start_mul(64'h1234, 64'h0, 1'b1);
    wait_done("done_zero");
    check("product_zero", product_E, '0);

    // start_E during RUN is ignored.
    d0 = done_cnt;
    start_mul(64'd7, 64'd9, 1'b1);
    repeat (4) tick();
    opA_E   = 64'd2;
    opB_E   = 64'd2;
    start_E = 1'b1;
    #1;
    check("stall_run_restart", stall_E, 1'b1);
    tick();
    start_E = 1'b0;
    wait_done("done_7x9");
    check("product_7x9", product_E, 64'd63);
    repeat (70) tick();
    check("single_done", N'(done_cnt - d0), N'(1));

    // Flush in RUN cycle 10: back to IDLE, no done, product unchanged.
    d0 = done_cnt;
    start_mul(64'd11, 64'd13, 1'b0);
    repeat (9) tick();
    flush_E = 1'b1;
    tick();
    flush_E = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_stall", stall_E, 1'b0);
    check("flush_done", done_E, 1'b0);
    repeat (70) tick();
    check("flush_no_done", N'(done_cnt - d0), '0);
    check("flush_product", product_E, 64'd63);

    // start and flush together in IDLE: flush wins.
    opA_E   = 64'd5;
    opB_E   = 64'd5;
    start_E = 1'b1;
    flush_E = 1'b1;
    #1;
    check("startflush_stall", stall_E, 1'b0);
    tick();
    start_E = 1'b0;
    flush_E = 1'b0;
    check("startflush_busy", busy, 1'b0);

    // Random operands through the scoreboard.
    for (int i = 0; i < 3; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      start_mul(a, b, 1'b1);
      wait_done("done_rand");
    end

    // Asynchronous reset mid-RUN aborts with no done pulse.
    d0 = done_cnt;
    start_mul(64'd6, 64'd6, 1'b0);
    repeat (20) tick();
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_stall", stall_E, 1'b0);
    check("arst_done", done_E, 1'b0);
    check("arst_product", product_E, '0);
    tick();
    reset = 1'b0;
    tick();
    check("arst_no_done", N'(done_cnt - d0), '0);
    start_mul(64'd4, 64'd4, 1'b1);
    wait_done("done_4x4");
    check("product_4x4", product_E, 64'd16);

    repeat (5) tick();
    check("sb_drained", N'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
